// File: rtl/ddr_cmd_encoder.sv
`default_nettype none
// ============================================================================
// Module      : ddr_cmd_encoder
// Description : Turns a registered 4-slot decoded DDR command bundle into
//               DDR4 pin-level command/address for a 4-phase PHY. Tracks the
//               CKE / self-refresh state across the four slots, counts reads
//               in flight and raises sticky error flags.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   ddr_<cmd>[3:0]         per-slot command flags (slot 0 earliest)
//   ddr_bg/bank/row/col    per-slot bank group, bank, row, column
//   rd_done[2:0]           read bursts returned this cycle (0..4)
//   phy_cs_n[7:0]          chip select, bit [2*s+r] = slot s, rank r
//   phy_act_n[3:0]         per-slot ACT_n
//   phy_addr[4*17-1:0]     per-slot A[16:0] (A16..A14 = RAS_n/CAS_n/WE_n)
//   phy_bg / phy_ba        per-slot bank group / bank
//   phy_cke[3:0]           per-slot CKE
//   rd_outstanding         reads issued but not yet returned
//   in_self_refresh        CKE state after slot 3 of the last cycle
//   err_multi_cmd          sticky: more than one command flag in a slot
//   err_sr_violation       sticky: command issued while in self-refresh
//   err_rd_count           sticky: read counter overflow / underflow
//
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_cmd_encoder #(
    parameter int ROW_W    = 17,
    parameter int COL_W    = 10,
    parameter int BG_W     = 2,
    parameter int BANK_W   = 2,
    parameter int RD_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            ddr_write,
    input  logic [3:0]            ddr_read,
    input  logic [3:0]            ddr_pre,
    input  logic [3:0]            ddr_act,
    input  logic [3:0]            ddr_ref,
    input  logic [3:0]            ddr_zq,
    input  logic [3:0]            ddr_nop,
    input  logic [3:0]            ddr_sre,
    input  logic [3:0]            ddr_srx,
    input  logic [3:0]            ddr_ap,
    input  logic [3:0]            ddr_pall,
    input  logic [3:0]            ddr_rank,
    input  logic [4*BG_W-1:0]     ddr_bg,
    input  logic [4*BANK_W-1:0]   ddr_bank,
    input  logic [4*ROW_W-1:0]    ddr_row,
    input  logic [4*COL_W-1:0]    ddr_col,
    input  logic [2:0]            rd_done,
    output logic [7:0]            phy_cs_n,
    output logic [3:0]            phy_act_n,
    output logic [4*17-1:0]       phy_addr,
    output logic [4*BG_W-1:0]     phy_bg,
    output logic [4*BANK_W-1:0]   phy_ba,
    output logic [3:0]            phy_cke,
    output logic [RD_CNT_W-1:0]   rd_outstanding,
    output logic                  in_self_refresh,
    output logic                  err_multi_cmd,
    output logic                  err_sr_violation,
    output logic                  err_rd_count
);

    localparam int c_SLOTS     = 4;
    localparam int c_ADDR_W    = 17;
    localparam int c_CNT_EXT_W = RD_CNT_W + 2;
    localparam logic [RD_CNT_W-1:0] c_RD_MAX = '1;

    // Selected command per slot, after priority resolution
    localparam logic [3:0] c_CMD_NONE = 4'd0;
    localparam logic [3:0] c_CMD_ACT  = 4'd1;
    localparam logic [3:0] c_CMD_RD   = 4'd2;
    localparam logic [3:0] c_CMD_WR   = 4'd3;
    localparam logic [3:0] c_CMD_PRE  = 4'd4;
    localparam logic [3:0] c_CMD_REF  = 4'd5;
    localparam logic [3:0] c_CMD_ZQ   = 4'd6;
    localparam logic [3:0] c_CMD_SRE  = 4'd7;
    localparam logic [3:0] c_CMD_SRX  = 4'd8;

    typedef enum logic [0:0] {
        ST_ACTIVE   = 1'b0,
        ST_SELF_REF = 1'b1
    } cke_state_e;

    cke_state_e r_state;
    cke_state_e w_state_next;

    logic [7:0]               r_cs_n, w_cs_n;
    logic [3:0]               r_act_n, w_act_n;
    logic [4*c_ADDR_W-1:0]    r_addr, w_addr;
    logic [4*BG_W-1:0]        r_bg, w_bg;
    logic [4*BANK_W-1:0]      r_ba, w_ba;
    logic [3:0]               r_cke, w_cke;
    logic [RD_CNT_W-1:0]      r_rd_cnt, w_rd_next;
    logic                     r_err_multi, r_err_sr, r_err_rd;
    logic                     w_multi, w_sr_viol, w_rd_err;
    logic [2:0]               w_rd_slots;

    logic [7:0]               w_flags;
    logic [3:0]               w_cmd;
    logic [11:0]              w_col;
    logic [c_ADDR_W-1:0]      w_row;
    logic [c_ADDR_W-1:0]      w_a;
    logic [c_CNT_EXT_W-1:0]   w_sum;
    logic [c_CNT_EXT_W-1:0]   w_diff;

    // ------------------------------------------------------------------------
    // Slot walk: priority-resolve each slot, advance the CKE state through
    // slots 0..3 in order, then encode pins. The state seen by slot s is the
    // state left behind by slot s-1 within the same cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cs_n       = '1;
        w_act_n      = '1;
        w_addr       = '0;
        w_bg         = '0;
        w_ba         = '0;
        w_cke        = '1;
        w_multi      = 1'b0;
        w_sr_viol    = 1'b0;
        w_rd_slots   = '0;
        w_flags      = '0;
        w_cmd        = c_CMD_NONE;
        w_col        = '0;
        w_row        = '0;
        w_a          = '0;

        for (int s = 0; s < c_SLOTS; s++) begin
            // Bit order matches command priority: bit 0 wins
            w_flags = {ddr_srx[s], ddr_sre[s], ddr_zq[s], ddr_ref[s],
                       ddr_pre[s], ddr_write[s], ddr_read[s], ddr_act[s]};

            w_col = '0;
            for (int b = 0; b < COL_W && b < 12; b++)
                w_col[b] = ddr_col[s*COL_W + b];
            w_row = '0;
            for (int b = 0; b < ROW_W && b < c_ADDR_W; b++)
                w_row[b] = ddr_row[s*ROW_W + b];

            if ($countones(w_flags) > 1)
                w_multi = 1'b1;

            if (ddr_nop[s] || (w_flags == 8'd0)) w_cmd = c_CMD_NONE;
            else if (w_flags[0])                 w_cmd = c_CMD_ACT;
            else if (w_flags[1])                 w_cmd = c_CMD_RD;
            else if (w_flags[2])                 w_cmd = c_CMD_WR;
            else if (w_flags[3])                 w_cmd = c_CMD_PRE;
            else if (w_flags[4])                 w_cmd = c_CMD_REF;
            else if (w_flags[5])                 w_cmd = c_CMD_ZQ;
            else if (w_flags[6])                 w_cmd = c_CMD_SRE;
            else                                 w_cmd = c_CMD_SRX;

            case (w_state_next)
                ST_ACTIVE: begin
                    if (w_cmd == c_CMD_SRE)
                        w_state_next = ST_SELF_REF;
                    else if (w_cmd == c_CMD_SRX)
                        w_cmd = c_CMD_NONE;   // redundant exit, harmless
                end
                ST_SELF_REF: begin
                    if (w_cmd == c_CMD_SRX) begin
                        w_state_next = ST_ACTIVE;
                        w_cmd        = c_CMD_NONE; // SRX is a deselect with CKE high
                    end else if (w_cmd == c_CMD_SRE) begin
                        w_cmd = c_CMD_NONE;        // redundant entry, harmless
                    end else if (w_cmd != c_CMD_NONE) begin
                        w_sr_viol = 1'b1;          // DRAM is asleep; drop it
                        w_cmd     = c_CMD_NONE;
                    end
                end
                default: w_state_next = ST_ACTIVE;
            endcase

            w_cke[s] = (w_state_next == ST_ACTIVE);

            w_a = '0;
            case (w_cmd)
                c_CMD_ACT: w_a = w_row;
                // RAS_n CAS_n WE_n A13 BC_n A11 AP A9..A0
                c_CMD_RD:  w_a = {1'b1, 1'b0, 1'b1, w_col[11], 1'b1, w_col[10],
                                  ddr_ap[s], w_col[9:0]};
                c_CMD_WR:  w_a = {1'b1, 1'b0, 1'b0, w_col[11], 1'b1, w_col[10],
                                  ddr_ap[s], w_col[9:0]};
                c_CMD_PRE: w_a = {3'b010, 3'b000, ddr_pall[s], 10'd0};
                c_CMD_REF,
                c_CMD_SRE: w_a = {3'b001, 14'd0};
                c_CMD_ZQ:  w_a = {3'b110, 3'b000, 1'b1, 10'd0};
                default:   w_a = '0;
            endcase

            if (w_cmd != c_CMD_NONE) begin
                w_cs_n[2*s + (ddr_rank[s] ? 1 : 0)] = 1'b0;
                w_act_n[s]                        = (w_cmd != c_CMD_ACT);
                w_addr[s*c_ADDR_W +: c_ADDR_W]    = w_a;
                w_bg[s*BG_W +: BG_W]              = ddr_bg[s*BG_W +: BG_W];
                w_ba[s*BANK_W +: BANK_W]          = ddr_bank[s*BANK_W +: BANK_W];
            end

            if (w_cmd == c_CMD_RD)
                w_rd_slots = w_rd_slots + 3'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Outstanding-read counter with saturation at both ends. The sum is
    // widened so that neither the add nor the compare can wrap.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd_next = r_rd_cnt;
        w_rd_err  = 1'b0;
        w_diff    = '0;
        w_sum     = c_CNT_EXT_W'(r_rd_cnt) + c_CNT_EXT_W'(w_rd_slots);
        if (w_sum < c_CNT_EXT_W'(rd_done)) begin
            w_rd_next = '0;
            w_rd_err  = 1'b1;
        end else begin
            w_diff = w_sum - c_CNT_EXT_W'(rd_done);
            if (w_diff > c_CNT_EXT_W'(c_RD_MAX)) begin
                w_rd_next = c_RD_MAX;
                w_rd_err  = 1'b1;
            end else begin
                w_rd_next = w_diff[RD_CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACTIVE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_n      <= '1;
            r_act_n     <= '1;
            r_addr      <= '0;
            r_bg        <= '0;
            r_ba        <= '0;
            r_cke       <= '1;
            r_rd_cnt    <= '0;
            r_err_multi <= 1'b0;
            r_err_sr    <= 1'b0;
            r_err_rd    <= 1'b0;
        end else begin
            r_cs_n      <= w_cs_n;
            r_act_n     <= w_act_n;
            r_addr      <= w_addr;
            r_bg        <= w_bg;
            r_ba        <= w_ba;
            r_cke       <= w_cke;
            r_rd_cnt    <= w_rd_next;
            r_err_multi <= r_err_multi | w_multi;
            r_err_sr    <= r_err_sr    | w_sr_viol;
            r_err_rd    <= r_err_rd    | w_rd_err;
        end
    end

    assign phy_cs_n         = r_cs_n;
    assign phy_act_n        = r_act_n;
    assign phy_addr         = r_addr;
    assign phy_bg           = r_bg;
    assign phy_ba           = r_ba;
    assign phy_cke          = r_cke;
    assign rd_outstanding   = r_rd_cnt;
    assign in_self_refresh  = (r_state == ST_SELF_REF);
    assign err_multi_cmd    = r_err_multi;
    assign err_sr_violation = r_err_sr;
    assign err_rd_count     = r_err_rd;

endmodule
`default_nettype wire

// File: tb/tb_ddr_cmd_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_cmd_encoder
// Description : Self-checking bench for ddr_cmd_encoder. Each step computes
//               the expected registered outputs from a behavioural model,
//               queues them, clocks the DUT and compares one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_cmd_encoder;

    localparam int K_NONE = 0;
    localparam int K_ACT  = 1;
    localparam int K_RD   = 2;
    localparam int K_WR   = 3;
    localparam int K_PRE  = 4;
    localparam int K_REF  = 5;
    localparam int K_ZQ   = 6;
    localparam int K_SRE  = 7;
    localparam int K_SRX  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ddr_write, ddr_read, ddr_pre, ddr_act, ddr_ref, ddr_zq;
    logic [3:0]  ddr_nop, ddr_sre, ddr_srx, ddr_ap, ddr_pall, ddr_rank;
    logic [7:0]  ddr_bg, ddr_bank;
    logic [67:0] ddr_row;
    logic [39:0] ddr_col;
    logic [2:0]  rd_done;

    logic [7:0]  phy_cs_n;
    logic [3:0]  phy_act_n;
    logic [67:0] phy_addr;
    logic [7:0]  phy_bg, phy_ba;
    logic [3:0]  phy_cke;
    logic [7:0]  rd_outstanding;
    logic        in_self_refresh, err_multi_cmd, err_sr_violation, err_rd_count;

    typedef struct packed {
        logic [7:0]  cs_n;
        logic [3:0]  act_n;
        logic [67:0] addr;
        logic [7:0]  bg;
        logic [7:0]  ba;
        logic [3:0]  cke;
        logic [7:0]  rd;
        logic        sr;
        logic        em;
        logic        es;
        logic        er;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_mis = 0;

    // model state
    bit   m_sr;
    int   m_cnt;
    bit   m_em, m_es, m_er;

    ddr_cmd_encoder dut (
        .clk(clk), .rst(rst),
        .ddr_write(ddr_write), .ddr_read(ddr_read), .ddr_pre(ddr_pre),
        .ddr_act(ddr_act), .ddr_ref(ddr_ref), .ddr_zq(ddr_zq),
        .ddr_nop(ddr_nop), .ddr_sre(ddr_sre), .ddr_srx(ddr_srx),
        .ddr_ap(ddr_ap), .ddr_pall(ddr_pall), .ddr_rank(ddr_rank),
        .ddr_bg(ddr_bg), .ddr_bank(ddr_bank), .ddr_row(ddr_row),
        .ddr_col(ddr_col), .rd_done(rd_done),
        .phy_cs_n(phy_cs_n), .phy_act_n(phy_act_n), .phy_addr(phy_addr),
        .phy_bg(phy_bg), .phy_ba(phy_ba), .phy_cke(phy_cke),
        .rd_outstanding(rd_outstanding), .in_self_refresh(in_self_refresh),
        .err_multi_cmd(err_multi_cmd), .err_sr_violation(err_sr_violation),
        .err_rd_count(err_rd_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ddr_write = '0; ddr_read = '0; ddr_pre = '0; ddr_act = '0;
        ddr_ref = '0; ddr_zq = '0; ddr_sre = '0; ddr_srx = '0;
        ddr_ap = '0; ddr_pall = '0; ddr_rank = '0; ddr_nop = 4'hF;
        ddr_bg = '0; ddr_bank = '0; ddr_row = '0; ddr_col = '0;
        rd_done = '0;
    endtask

    task automatic set_cmd(input int s, input int k, input logic rank);
        ddr_nop[s]  = 1'b0;
        ddr_rank[s] = rank;
        case (k)
            K_ACT: ddr_act[s]   = 1'b1;
            K_RD:  ddr_read[s]  = 1'b1;
            K_WR:  ddr_write[s] = 1'b1;
            K_PRE: ddr_pre[s]   = 1'b1;
            K_REF: ddr_ref[s]   = 1'b1;
            K_ZQ:  ddr_zq[s]    = 1'b1;
            K_SRE: ddr_sre[s]   = 1'b1;
            K_SRX: ddr_srx[s]   = 1'b1;
            default: ;
        endcase
    endtask

    // Behavioural reference: what the pins should show one edge after the
    // current inputs are sampled.
    task automatic model(output exp_t e);
        logic [7:0]  f;
        logic [16:0] a;
        logic [11:0] c;
        int k, nrd, nxt;
        e = '0;
        e.cs_n = '1; e.act_n = '1; e.cke = '1;
        if (rst) begin
            m_sr = 0; m_cnt = 0; m_em = 0; m_es = 0; m_er = 0;
        end else begin
            nrd = 0;
            for (int s = 0; s < 4; s++) begin
                f = {ddr_srx[s], ddr_sre[s], ddr_zq[s], ddr_ref[s],
                     ddr_pre[s], ddr_write[s], ddr_read[s], ddr_act[s]};
                if ($countones(f) > 1) m_em = 1;
                k = K_NONE;
                if (!ddr_nop[s])
                    for (int b = 7; b >= 0; b--)
                        if (f[b]) k = b + 1;
                if (m_sr) begin
                    if (k == K_SRX) begin m_sr = 0; k = K_NONE; end
                    else if (k == K_SRE) k = K_NONE;
                    else if (k != K_NONE) begin m_es = 1; k = K_NONE; end
                end else begin
                    if (k == K_SRE) m_sr = 1;
                    else if (k == K_SRX) k = K_NONE;
                end
                e.cke[s] = !m_sr;
                if (k != K_NONE) begin
                    c = {2'b00, ddr_col[s*10 +: 10]};
                    a = '0;
                    case (k)
                        K_ACT: begin e.act_n[s] = 1'b0; a = ddr_row[s*17 +: 17]; end
                        K_RD:  a = {3'b101, c[11], 1'b1, c[10], ddr_ap[s], c[9:0]};
                        K_WR:  a = {3'b100, c[11], 1'b1, c[10], ddr_ap[s], c[9:0]};
                        K_PRE: a = {3'b010, 3'b000, ddr_pall[s], 10'd0};
                        K_REF, K_SRE: a = {3'b001, 14'd0};
                        K_ZQ:  a = {3'b110, 3'b000, 1'b1, 10'd0};
                        default: ;
                    endcase
                    e.addr[s*17 +: 17] = a;
                    e.cs_n[2*s + int'(ddr_rank[s])] = 1'b0;
                    e.bg[s*2 +: 2] = ddr_bg[s*2 +: 2];
                    e.ba[s*2 +: 2] = ddr_bank[s*2 +: 2];
                    if (k == K_RD) nrd++;
                end
            end
            nxt = m_cnt + nrd - int'(rd_done);
            if (nxt > 255) begin nxt = 255; m_er = 1; end
            else if (nxt < 0) begin nxt = 0; m_er = 1; end
            m_cnt = nxt;
        end
        e.rd = 8'(m_cnt);
        e.sr = m_sr; e.em = m_em; e.es = m_es; e.er = m_er;
    endtask

    task automatic step();
        exp_t e;
        model(e);
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            n_vec++; n_mis++;
            $error("FAIL scoreboard: observed empty queue expected entry");
        end else begin
            e = q.pop_front();
            chk("cs_n",  phy_cs_n,         e.cs_n);
            chk("act_n", phy_act_n,        e.act_n);
            chk("addr",  phy_addr,         e.addr);
            chk("bg",    phy_bg,           e.bg);
            chk("ba",    phy_ba,           e.ba);
            chk("cke",   phy_cke,          e.cke);
            chk("rd_out", rd_outstanding,  e.rd);
            chk("in_sr", in_self_refresh,  e.sr);
            chk("e_mc",  err_multi_cmd,    e.em);
            chk("e_sr",  err_sr_violation, e.es);
            chk("e_rd",  err_rd_count,     e.er);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        step();
        step();
        chk("rst_cs", phy_cs_n, 8'hFF);
        chk("rst_cke", phy_cke, 4'hF);
        rst = 1'b0;

        // Idle
        step();
        chk("idle_act", phy_act_n, 4'hF);

        // ACT slot0 rank1 + RD slot2 with auto-precharge
        idle();
        set_cmd(0, K_ACT, 1'b1);
        ddr_bg[1:0] = 2'd2; ddr_bank[1:0] = 2'd1; ddr_row[16:0] = 17'h1ABCD;
        set_cmd(2, K_RD, 1'b0);
        ddr_col[29:20] = 10'h3F8; ddr_ap[2] = 1'b1;
        ddr_bg[5:4] = 2'd3; ddr_bank[5:4] = 2'd2;
        step();
        chk("act_cs", phy_cs_n[1:0], 2'b01);
        chk("act_actn", phy_act_n[0], 1'b0);
        chk("act_addr", phy_addr[16:0], 17'h1ABCD);
        chk("rd_addr", phy_addr[50:34], 17'h157F8);
        chk("rd_cnt1", rd_outstanding, 8'd1);

        // PRE all, WR, ZQ, REF across the four slots
        idle();
        set_cmd(0, K_PRE, 1'b0); ddr_pall[0] = 1'b1;
        set_cmd(1, K_WR, 1'b0);  ddr_col[19:10] = 10'h155;
        set_cmd(2, K_ZQ, 1'b0);
        set_cmd(3, K_REF, 1'b1); ddr_bg[7:6] = 2'd1; ddr_bank[7:6] = 2'd3;
        step();
        chk("pre_addr", phy_addr[16:0], 17'h08400);

        // ACT and RD in one slot: ACT wins, multi-cmd flagged
        idle();
        set_cmd(0, K_ACT, 1'b0); ddr_read[0] = 1'b1; ddr_row[16:0] = 17'h00123;
        step();
        chk("multi_flag", err_multi_cmd, 1'b1);

        // SRE in slot1, RD in slot3 is blocked
        idle();
        set_cmd(1, K_SRE, 1'b0);
        set_cmd(3, K_RD, 1'b1);
        step();
        chk("sre_cke", phy_cke, 4'b0001);
        chk("sre_viol", err_sr_violation, 1'b1);

        // SRX in slot0 then a legal RD
        idle();
        set_cmd(0, K_SRX, 1'b0);
        set_cmd(1, K_RD, 1'b1);
        step();
        chk("srx_cke", phy_cke, 4'hF);
        chk("srx_insr", in_self_refresh, 1'b0);

        // SRX while active is a silent deselect
        idle();
        set_cmd(2, K_SRX, 1'b1);
        step();

        // Read bursts, returns, net-out and underflow
        for (int i = 0; i < 3; i++) begin
            idle();
            for (int s = 0; s < 4; s++) set_cmd(s, K_RD, s[0]);
            rd_done = 3'd2;
            step();
        end
        idle();
        for (int s = 0; s < 4; s++) set_cmd(s, K_RD, 1'b0);
        rd_done = 3'd4;
        step();
        for (int i = 0; i < 3; i++) begin
            idle();
            rd_done = 3'd4;
            step();
        end
        chk("uflow_cnt", rd_outstanding, 8'd0);
        chk("uflow_err", err_rd_count, 1'b1);

        // Reset out of self-refresh with reads pending
        idle();
        for (int s = 0; s < 4; s++) set_cmd(s, K_RD, 1'b0);
        step();
        idle();
        set_cmd(0, K_RD, 1'b1);
        set_cmd(1, K_SRE, 1'b0);
        step();
        chk("pre_rst_cnt", rd_outstanding, 8'd5);
        idle();
        set_cmd(0, K_ACT, 1'b0);
        rst = 1'b1;
        step();
        chk("rst2_cke", phy_cke, 4'hF);
        chk("rst2_cnt", rd_outstanding, 8'd0);
        chk("rst2_errs", {err_multi_cmd, err_sr_violation, err_rd_count}, 3'b000);
        rst = 1'b0;

        // Overflow: 64 cycles of four reads
        for (int i = 0; i < 64; i++) begin
            idle();
            for (int s = 0; s < 4; s++) set_cmd(s, K_RD, 1'b1);
            step();
        end
        chk("oflow_cnt", rd_outstanding, 8'd255);
        chk("oflow_err", err_rd_count, 1'b1);

        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
